// File: rtl/wram_rd_port.sv
// Weight-RAM wrapper: byte-strobed writes take priority over reads; read requests that cannot
// issue immediately wait in an in-order FIFO, and each return is a registered alloc beat.
module wram_rd_port #(
  parameter int RAM_WIDTH  = 128,
  parameter int RAM_DEPTH  = 256,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_vld,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [RAM_WIDTH-1:0]  wr_data,
  input  logic [STRB_WIDTH-1:0] wr_strb,
  input  logic                  ram_read_vld,
  input  logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic                  ram_buff_alloc_vld,
  output logic [ADDR_WIDTH-1:0] ram_buff_alloc_addr,
  output logic [RAM_WIDTH-1:0]  ram_buff_alloc_data,
  output logic                  rd_fifo_full,
  output logic                  rd_ovf_err,
  input  logic                  err_clr,
  output logic                  rd_idle
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(FIFO_DEPTH);

  logic [RAM_WIDTH-1:0]  mem [RAM_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_q [FIFO_DEPTH];

  logic [PTR_W-1:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt, count_nxt;
  logic                  fifo_empty, fifo_is_full;
  logic                  issue_p0, deq_p0, enq_need_p0, enq_p0, drop_p0;
  logic [ADDR_WIDTH-1:0] issue_addr_p0;

  // Stage p0: arbitration between writes, the FIFO head and the bypass path
  always_comb begin
    fifo_empty    = (wr_ptr == rd_ptr);
    fifo_is_full  = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                    (wr_ptr[IDX_W] != rd_ptr[IDX_W]);
    issue_p0      = ~wr_vld & (~fifo_empty | ram_read_vld);
    deq_p0        = ~wr_vld & ~fifo_empty;
    issue_addr_p0 = fifo_empty ? ram_read_addr : fifo_q[rd_ptr[IDX_W-1:0]];
    // A queued request must not be overtaken, so a non-empty FIFO forces new requests to enqueue.
    enq_need_p0   = ram_read_vld & (wr_vld | ~fifo_empty);
    drop_p0       = enq_need_p0 & fifo_is_full & ~deq_p0;
    enq_p0        = enq_need_p0 & ~drop_p0;
    wr_ptr_nxt    = wr_ptr + PTR_W'(enq_p0);
    rd_ptr_nxt    = rd_ptr + PTR_W'(deq_p0);
    count_nxt     = wr_ptr_nxt - rd_ptr_nxt;
  end

  always_ff @(posedge clk) begin
    if (enq_p0) begin
      fifo_q[wr_ptr[IDX_W-1:0]] <= ram_read_addr;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_vld && !rst) begin
      for (int b = 0; b < STRB_WIDTH; b++) begin
        if (wr_strb[b]) begin
          mem[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  // Stage p1: registered alloc beat and status
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr              <= '0;
      rd_ptr              <= '0;
      ram_buff_alloc_vld  <= 1'b0;
      ram_buff_alloc_addr <= '0;
      ram_buff_alloc_data <= '0;
      rd_fifo_full        <= 1'b0;
      rd_idle             <= 1'b1;
      rd_ovf_err          <= 1'b0;
    end else begin
      wr_ptr             <= wr_ptr_nxt;
      rd_ptr             <= rd_ptr_nxt;
      ram_buff_alloc_vld <= issue_p0;
      if (issue_p0) begin
        ram_buff_alloc_addr <= issue_addr_p0;
        ram_buff_alloc_data <= mem[issue_addr_p0];
      end
      rd_fifo_full <= (count_nxt == DEPTH_CNT);
      rd_idle      <= (count_nxt == '0) & ~issue_p0;
      rd_ovf_err   <= drop_p0 | (rd_ovf_err & ~err_clr);
    end
  end

endmodule
